mux_bank: RTL and testbench
===========================

Name: mux_bank

Overview:
- Registered multiplexer bank containing three independent byte-wide selectors: 2:1, 4:1 and 8:1.
- All three share data inputs a..h.
- Each selector has its own select input and its own registered output.
- Used as the datapath-select building block for the MPU. Each selector is a reusable combinational submodule followed by a shared output register stage.

Parameters:
- WIDTH, 8, bit width of every data input and every output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data input 0 (used by all three selectors).
- b  input  WIDTH  data input 1 (used by all three selectors).
- c  input  WIDTH  data input 2 (4:1 and 8:1 only).
- d  input  WIDTH  data input 3 (4:1 and 8:1 only).
- e  input  WIDTH  data input 4 (8:1 only).
- f  input  WIDTH  data input 5 (8:1 only).
- g  input  WIDTH  data input 6 (8:1 only).
- h  input  WIDTH  data input 7 (8:1 only).
- s1  input  1  select for the 2:1 selector.
- s2  input  2  select for the 4:1 selector.
- s3  input  3  select for the 8:1 selector.
- mux_two_out  output  WIDTH  registered 2:1 result.
- mux_four_out  output  WIDTH  registered 4:1 result.
- mux_eight_out  output  WIDTH  registered 8:1 result.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, all three outputs are forced to 0 immediately, independent of clk. The first capture occurs on the first rising clk edge with rst_n=1.
- 2:1 selection:
  - s1=0 selects a.
  - s1=1 selects b.
- 4:1 selection:
  - s2=00 -> a, 01 -> b, 10 -> c, 11 -> d.
- 8:1 selection:
  - s3=000 -> a, 001 -> b, 010 -> c, 011 -> d.
  - s3=100 -> e, 101 -> f, 110 -> g, 111 -> h.
- Select values are binary-weighted: MSB picks the upper half.
- Latency: exactly 1 cycle. The output after a rising edge equals the selection of the inputs and selects sampled at that edge.
- No enable; every output register reloads on every clock edge.
- Independence: the three selectors share no select state. Changing one select never affects another output.
- Width: pure bit-copy of the selected input. No arithmetic, no sign or zero extension; all bits pass unchanged.
- Unused inputs: c..h are ignored by the 2:1 path; e..h are ignored by the 4:1 path. Toggling them must not change those outputs.
- Simultaneous changes: data and select changes in the same cycle are both captured at the next edge. No glitch ever appears on the registered outputs.
- Reset mid-operation: asserting rst_n at any time zeroes the outputs asynchronously. Deassertion resumes normal capture at the next edge; no other state exists.
- Unknown select (X/Z) is outside the legal operating range. Synthesis behaviour is don't-care; simulation may propagate X.
- Structure: the combinational selection lives in three submodules instantiated once each, named after their function (two-, four- and eight-way). The register stage is in mux_bank.

Test Plan:
- Setup for all directed cases: a=00, b=FF, c=AA, d=55, e=CC, f=33, g=E0, h=0F (hex).
- Reset: hold rst_n=0 with any selects -> all outputs 00. Assert rst_n=0 mid-run between clock edges -> outputs drop to 00 before the next edge.
- 2:1 sweep: s1=0 then 1 -> mux_two_out=00 then FF, each one cycle after the select changes.
- 4:1 sweep: s2=00,01,10,11 -> mux_four_out=00, FF, AA, 55, each one cycle after the select changes.
- 8:1 sweep: s3=000..111 -> mux_eight_out=00, FF, AA, 55, CC, 33, E0, 0F, each one cycle after the select changes.
- Independence and latency: hold s1=1, s2=10, s3=111 while changing only h to 5A:
  - mux_eight_out becomes 5A one cycle later.
  - mux_two_out stays FF.
  - mux_four_out stays AA.
- Simultaneous change: in one cycle set s3 from 000 to 100 and e to 81 -> mux_eight_out=81 after the next edge, with no intermediate value.

Source files
------------

// File: rtl/mux_bank.sv
// -----------------------------------------------------------------------------
// mux_bank
//   Registered multiplexer bank for the MPU datapath. Three independent
//   selectors (2:1, 4:1, 8:1) share the data inputs a..h; each has its own
//   select and its own output register. Latency is exactly one clock.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset, clears all outputs
//   a..h           WIDTH-bit data inputs (a,b: all; c,d: 4:1 and 8:1; e..h: 8:1)
//   s1             2:1 select   (0 -> a, 1 -> b)
//   s2             4:1 select   (binary index into a..d)
//   s3             8:1 select   (binary index into a..h)
//   mux_two_out    registered 2:1 result
//   mux_four_out   registered 4:1 result
//   mux_eight_out  registered 8:1 result
// -----------------------------------------------------------------------------

// Combinational 2:1 selector.
module mux_two_way #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    // NOTE: assigning a default before the selection keeps every path
    // driven, so no latch can be inferred even if a branch is missed.
    y = in0;
    if (sel) y = in1;
  end
endmodule

// Combinational 4:1 selector, binary-weighted select.
module mux_four_way #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = in0;
    case (sel)
      2'd0:    y = in0;
      2'd1:    y = in1;
      2'd2:    y = in2;
      default: y = in3;
    endcase
  end
endmodule

// Combinational 8:1 selector, binary-weighted select (MSB picks upper half).
module mux_eight_way #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = in0;
    case (sel)
      3'd0:    y = in0;
      3'd1:    y = in1;
      3'd2:    y = in2;
      3'd3:    y = in3;
      3'd4:    y = in4;
      3'd5:    y = in5;
      3'd6:    y = in6;
      default: y = in7;
    endcase
  end
endmodule

// Top: three selectors followed by a shared output register stage.
module mux_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             s1,
  input  logic [1:0]       s2,
  input  logic [2:0]       s3,
  output logic [WIDTH-1:0] mux_two_out,
  output logic [WIDTH-1:0] mux_four_out,
  output logic [WIDTH-1:0] mux_eight_out
);

  logic [WIDTH-1:0] mux_two_d,   mux_two_q;
  logic [WIDTH-1:0] mux_four_d,  mux_four_q;
  logic [WIDTH-1:0] mux_eight_d, mux_eight_q;

  mux_two_way #(.WIDTH(WIDTH)) u_two (
    .in0 (a),
    .in1 (b),
    .sel (s1),
    .y   (mux_two_d)
  );

  mux_four_way #(.WIDTH(WIDTH)) u_four (
    .in0 (a),
    .in1 (b),
    .in2 (c),
    .in3 (d),
    .sel (s2),
    .y   (mux_four_d)
  );

  mux_eight_way #(.WIDTH(WIDTH)) u_eight (
    .in0 (a),
    .in1 (b),
    .in2 (c),
    .in3 (d),
    .in4 (e),
    .in5 (f),
    .in6 (g),
    .in7 (h),
    .sel (s3),
    .y   (mux_eight_d)
  );

  // No enable: every register reloads on every edge, so the registered
  // outputs never show combinational glitches from simultaneous changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_two_q   <= '0;
      mux_four_q  <= '0;
      mux_eight_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make all three registers sample the
      // pre-edge values together, independent of statement order.
      mux_two_q   <= mux_two_d;
      mux_four_q  <= mux_four_d;
      mux_eight_q <= mux_eight_d;
    end
  end

  assign mux_two_out   = mux_two_q;
  assign mux_four_out  = mux_four_q;
  assign mux_eight_out = mux_eight_q;

endmodule

// File: tb/tb_mux_bank.sv
// -----------------------------------------------------------------------------
// tb_mux_bank
//   Self-checking bench for mux_bank. A table of vectors (data, selects and
//   the expected registered outputs) is driven on the falling edge; the
//   expected outputs are pushed to a scoreboard queue at drive time and
//   popped and compared shortly after the capturing rising edge. Reset and
//   the simultaneous data/select change are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mux_bank;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             s1;
  logic [1:0]       s2;
  logic [2:0]       s3;
  logic [WIDTH-1:0] mux_two_out, mux_four_out, mux_eight_out;

  mux_bank #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .e             (e),
    .f             (f),
    .g             (g),
    .h             (h),
    .s1            (s1),
    .s2            (s2),
    .s3            (s3),
    .mux_two_out   (mux_two_out),
    .mux_four_out  (mux_four_out),
    .mux_eight_out (mux_eight_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data is {h,g,f,e,d,c,b,a}: byte 0 is a, byte 7 is h.
  typedef struct {
    logic [7:0][7:0] data;
    logic            s1;
    logic [1:0]      s2;
    logic [2:0]      s3;
    logic [7:0]      exp_two;
    logic [7:0]      exp_four;
    logic [7:0]      exp_eight;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] two;
    logic [7:0] four;
    logic [7:0] eight;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  localparam logic [7:0][7:0] BASE =
    {8'h0F, 8'hE0, 8'h33, 8'hCC, 8'h55, 8'hAA, 8'hFF, 8'h00};
  localparam logic [7:0][7:0] BASE_H5A =
    {8'h5A, 8'hE0, 8'h33, 8'hCC, 8'h55, 8'hAA, 8'hFF, 8'h00};
  // c..h changed, a and b unchanged.
  localparam logic [7:0][7:0] ALT_HI =
    {8'hF0, 8'h1F, 8'hCC, 8'h33, 8'hAA, 8'h55, 8'hFF, 8'h00};
  // Asymmetric a/b patterns to catch bit swaps.
  localparam logic [7:0][7:0] ALT_AB =
    {8'h0F, 8'hE0, 8'h33, 8'hCC, 8'h55, 8'hAA, 8'hC3, 8'h3C};

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0][7:0] data, input logic s1_v,
                       input logic [1:0] s2_v, input logic [2:0] s3_v);
    a = data[0]; b = data[1]; c = data[2]; d = data[3];
    e = data[4]; f = data[5]; g = data[6]; h = data[7];
    s1 = s1_v; s2 = s2_v; s3 = s3_v;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e2,
                           input logic [7:0] e4, input logic [7:0] e8);
    check({tag, ".two"},   mux_two_out,   e2);
    check({tag, ".four"},  mux_four_out,  e4);
    check({tag, ".eight"}, mux_eight_out, e8);
  endtask

  vec_t vecs[14];

  initial begin
    exp_t ex;

    // 2:1, 4:1 and 8:1 sweeps run together on the base data.
    vecs[0]  = '{BASE,     1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{BASE,     1'b1, 2'd1, 3'd1, 8'hFF, 8'hFF, 8'hFF};
    vecs[2]  = '{BASE,     1'b0, 2'd2, 3'd2, 8'h00, 8'hAA, 8'hAA};
    vecs[3]  = '{BASE,     1'b1, 2'd3, 3'd3, 8'hFF, 8'h55, 8'h55};
    vecs[4]  = '{BASE,     1'b0, 2'd0, 3'd4, 8'h00, 8'h00, 8'hCC};
    vecs[5]  = '{BASE,     1'b1, 2'd1, 3'd5, 8'hFF, 8'hFF, 8'h33};
    vecs[6]  = '{BASE,     1'b0, 2'd2, 3'd6, 8'h00, 8'hAA, 8'hE0};
    vecs[7]  = '{BASE,     1'b1, 2'd3, 3'd7, 8'hFF, 8'h55, 8'h0F};
    // Mixed selects.
    vecs[8]  = '{BASE,     1'b1, 2'd0, 3'd3, 8'hFF, 8'h00, 8'h55};
    vecs[9]  = '{BASE,     1'b0, 2'd3, 3'd6, 8'h00, 8'h55, 8'hE0};
    // Independence: hold selects, change only h.
    vecs[10] = '{BASE,     1'b1, 2'd2, 3'd7, 8'hFF, 8'hAA, 8'h0F};
    vecs[11] = '{BASE_H5A, 1'b1, 2'd2, 3'd7, 8'hFF, 8'hAA, 8'h5A};
    // Unused inputs toggled: 2:1 and 4:1 paths must ignore them.
    vecs[12] = '{ALT_HI,   1'b0, 2'd1, 3'd0, 8'h00, 8'hFF, 8'h00};
    vecs[13] = '{ALT_AB,   1'b1, 2'd0, 3'd1, 8'hC3, 8'h3C, 8'hC3};

    // Reset held with non-zero selects and data.
    rst_n = 1'b0;
    drive(BASE, 1'b1, 2'd3, 3'd7);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors via the scoreboard.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].data, vecs[i].s1, vecs[i].s2, vecs[i].s3);
      sb_q.push_back('{i, vecs[i].exp_two, vecs[i].exp_four, vecs[i].exp_eight});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        ex = sb_q.pop_front();
        check_all($sformatf("vec%0d", ex.idx), ex.two, ex.four, ex.eight);
      end
    end

    // Simultaneous change: s3 000 -> 100 and e -> 81 in the same cycle.
    @(negedge clk);
    drive(BASE, 1'b0, 2'd0, 3'd0);
    @(posedge clk);
    #1;
    check("simul_pre.eight", mux_eight_out, 8'h00);
    @(negedge clk);
    drive(BASE, 1'b0, 2'd0, 3'd4);
    e = 8'h81;
    #1;
    check("simul_before_edge.eight", mux_eight_out, 8'h00);
    @(posedge clk);
    #1;
    check("simul_after_edge.eight", mux_eight_out, 8'h81);

    // Reset mid-run between edges: outputs drop before the next edge.
    @(negedge clk);
    drive(BASE, 1'b1, 2'd2, 3'd7);
    @(posedge clk);
    #1;
    check_all("pre_reset", 8'hFF, 8'hAA, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_all("reset_over_edge", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset", 8'hFF, 8'hAA, 8'h0F);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
